// File: rtl/chase_ctrl.sv
// chase_ctrl: 16-LED chase sequencer. Prescaled step rate, wrap/bounce motion, trail pattern, stop/resume.
// Optional: define CHASE_BOUNCE_EN to build bounce mode (sw[5]); undefined, the chase always wraps.
module chase_ctrl #(
  parameter int NUM_LEDS = 16,
  parameter int BASE_DIV = 100000,
  parameter int POS_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stop,
  input  logic [7:0]          sw,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    pos,
  output logic                step_pulse,
  output logic                paused
);

  localparam int                  PRE_W     = $clog2(BASE_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(BASE_DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LED_RESET = NUM_LEDS'(1);

  typedef enum logic [1:0] {LOAD, RUN, PAUSE} state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                dir_q, dir_d;
  logic [3:0]          speed_q, speed_d;
  logic                cfg_dir_q, cfg_dir_d;
  logic                bounce_q, bounce_d;
  logic [1:0]          width_q, width_d;
  logic                step_pulse_q, step_pulse_d;
  logic                paused_q, paused_d;

  logic                step;
  logic [POS_W-1:0]    next_pos;
  logic                next_dir;
  logic                sw_bounce;

`ifdef CHASE_BOUNCE_EN
  assign sw_bounce = sw[5];
`else
  logic unused_sw5;
  assign sw_bounce  = 1'b0;
  assign unused_sw5 = sw[5];
`endif

  // Head bit plus width_m1 bits trailing behind it, opposite the direction of travel.
  function automatic logic [NUM_LEDS-1:0] trail(input logic [POS_W-1:0] head,
                                                input logic down,
                                                input logic [1:0] width_m1);
    logic [NUM_LEDS-1:0] t;
    logic [POS_W-1:0]    idx;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      if (k <= int'(width_m1)) begin
        idx    = down ? head + POS_W'(k) : head - POS_W'(k);
        t[idx] = 1'b1;
      end
    end
    return t;
  endfunction

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    led_d     = led_q;
    dir_d     = dir_q;
    speed_d   = speed_q;
    cfg_dir_d = cfg_dir_q;
    bounce_d  = bounce_q;
    width_d   = width_q;
    step      = 1'b0;
    next_pos  = pos_q;
    next_dir  = dir_q;

    case (state_q)
      LOAD: begin
        speed_d   = sw[3:0];
        cfg_dir_d = sw[4];
        bounce_d  = sw_bounce;
        width_d   = sw[7:6];
        dir_d     = sw[4];
        led_d     = trail(pos_q, sw[4], sw[7:6]);
        state_d   = RUN;
      end
      RUN: begin
        // A stop on the terminal cycle freezes the counters there, so the step fires right after resume.
        if (stop) begin
          state_d = PAUSE;
        end else begin
          pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
          if (pre_q == PRE_LAST) begin
            if (cnt_q == ~speed_q) begin
              cnt_d = '0;
              step  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (!stop) state_d = RUN;
      end
      default: state_d = LOAD;
    endcase

`ifdef CHASE_BOUNCE_EN
    if (bounce_q) begin
      if (!dir_q && pos_q == POS_LAST) begin
        next_pos = POS_LAST - 1'b1;
        next_dir = 1'b1;
      end else if (dir_q && pos_q == '0) begin
        next_pos = POS_W'(1);
        next_dir = 1'b0;
      end else begin
        next_pos = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
      end
    end else begin
      next_pos = cfg_dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
    end
`else
    next_pos = cfg_dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
`endif

    // Movement uses the config in force for the elapsed period; the fresh sw applies from here on.
    if (step) begin
      speed_d   = sw[3:0];
      cfg_dir_d = sw[4];
      bounce_d  = sw_bounce;
      width_d   = sw[7:6];
      pos_d     = next_pos;
      dir_d     = (bounce_q && sw_bounce) ? next_dir : sw[4];
      led_d     = trail(next_pos, dir_d, sw[7:6]);
    end

    step_pulse_d = step;
    paused_d     = (state_d == PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      pre_q        <= '0;
      cnt_q        <= '0;
      pos_q        <= '0;
      led_q        <= LED_RESET;
      dir_q        <= 1'b0;
      speed_q      <= '0;
      cfg_dir_q    <= 1'b0;
      bounce_q     <= 1'b0;
      width_q      <= '0;
      step_pulse_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
      speed_q      <= speed_d;
      cfg_dir_q    <= cfg_dir_d;
      bounce_q     <= bounce_d;
      width_q      <= width_d;
      step_pulse_q <= step_pulse_d;
      paused_q     <= paused_d;
    end
  end

  assign led        = led_q;
  assign pos        = pos_q;
  assign step_pulse = step_pulse_q;
  assign paused     = paused_q;

endmodule

// File: tb/tb_chase_ctrl.sv
// Testbench for chase_ctrl: directed scenarios plus randomized segments, checked against a cycle-level model.
// The model honours CHASE_BOUNCE_EN the same way the design build does.
module tb_chase_ctrl;

   localparam int N   = 16;
   localparam int DIV = 4;
`ifdef CHASE_BOUNCE_EN
   localparam bit BOUNCE_BUILT = 1'b1;
`else
   localparam bit BOUNCE_BUILT = 1'b0;
`endif

   localparam int M_LOAD  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stop = 1'b0;
   logic [7:0]  sw = 8'h00;
   logic [15:0] led;
   logic [3:0]  pos;
   logic        step_pulse;
   logic        paused;

   chase_ctrl #(.NUM_LEDS(N), .BASE_DIV(DIV), .POS_W(4)) dut (
      .clk(clk),
      .reset(reset),
      .stop(stop),
      .sw(sw),
      .led(led),
      .pos(pos),
      .step_pulse(step_pulse),
      .paused(paused)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int compareCount = 0;
   int mismatchCount = 0;

   // Reference model: mode, elapsed RUN cycles in the current period, and visible outputs.
   int          mMode = M_LOAD;
   int          mPos = 0;
   int          mDir = 0;
   int          mElapsed = 0;
   int          mPulse = 0;
   int          mPaused = 0;
   logic [7:0]  mCfg = 8'h00;
   logic [15:0] mLed = 16'h0001;
   bit          mValid = 1'b0;
   bit          stopState = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] pattern(input int p, input int down, input int w);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < w; k++) r[(p + (down != 0 ? k : N - k)) % N] = 1'b1;
      return r;
   endfunction

   function automatic bit bounceOn(input logic [7:0] c);
      return c[5] && BOUNCE_BUILT;
   endfunction

   function automatic int period(input logic [7:0] c);
      return DIV * (16 - int'(c[3:0]));
   endfunction

   function automatic bit stepDue();
      return (mMode == M_RUN) && (mElapsed == period(mCfg) - 1);
   endfunction

   task automatic moveChase(input logic [7:0] s);
      bit bnc;
      bit up;
      bnc = bounceOn(mCfg);
      up  = bnc ? (mDir == 0) : !mCfg[4];
      if (bnc && up && mPos == N - 1) begin
         mPos = N - 2;
         mDir = 1;
      end else if (bnc && !up && mPos == 0) begin
         mPos = 1;
         mDir = 0;
      end else begin
         mPos = (mPos + (up ? 1 : N - 1)) % N;
      end
      if (!(bnc && bounceOn(s))) mDir = int'(s[4]);
      mCfg  = s;
      mLed  = pattern(mPos, mDir, int'(s[7:6]) + 1);
      mPulse = 1;
   endtask

   // Advance the model across one clock edge given the inputs driven for that edge.
   task automatic modelStep(input bit r, input bit st, input logic [7:0] s);
      if (r) begin
         mMode = M_LOAD; mPos = 0; mDir = 0; mElapsed = 0;
         mPulse = 0; mPaused = 0; mLed = 16'h0001; mValid = 1'b1;
      end else begin
         mPulse = 0;
         if (mMode == M_LOAD) begin
            mCfg  = s;
            mDir  = int'(s[4]);
            mLed  = pattern(mPos, mDir, int'(s[7:6]) + 1);
            mMode = M_RUN;
         end else if (mMode == M_RUN) begin
            if (st) begin
               mMode = M_PAUSE;
            end else if (mElapsed == period(mCfg) - 1) begin
               mElapsed = 0;
               moveChase(s);
            end else begin
               mElapsed++;
            end
         end else if (!st) begin
            mMode = M_RUN;
         end
         mPaused = (mMode == M_PAUSE) ? 1 : 0;
      end
   endtask

   // One cycle: compare outputs at the falling edge, then drive the next inputs.
   task automatic applyStimulus(input bit r, input bit st, input logic [7:0] s);
      @(negedge clk);
      if (mValid) begin
         checkOutput("led", 32'(led), 32'(mLed));
         checkOutput("pos", 32'(pos), 32'(mPos));
         checkOutput("step_pulse", 32'(step_pulse), 32'(mPulse));
         checkOutput("paused", 32'(paused), 32'(mPaused));
      end
      reset = r;
      stop  = st;
      sw    = s;
      modelStep(r, st, s);
   endtask

   task automatic runQuiet(input int n, input logic [7:0] s);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, s);
   endtask

   task automatic restart(input logic [7:0] s);
      applyStimulus(1'b1, 1'b0, s);
      applyStimulus(1'b0, 1'b0, s);
   endtask

   task automatic runRandom(input int n, input logic [7:0] s);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < 6) stopState = !stopState;
         applyStimulus(1'b0, stopState, s);
      end
      stopState = 1'b0;
   endtask

   initial begin
      bit found;
      logic [7:0] s;

      // Basic timing and 16-step wrap back to LED 0.
      restart(8'h0F);
      runQuiet(5, 8'h0F);
      checkOutput("firstStepPos", 32'(pos), 32'd1);
      checkOutput("firstStepLed", 32'(led), 32'h0002);
      runQuiet(60, 8'h0F);
      checkOutput("wrapPos", 32'(pos), 32'd0);
      checkOutput("wrapLed", 32'(led), 32'h0001);
      checkOutput("wrapPulse", 32'(step_pulse), 32'd1);

      // Slowest speed with a four-wide trail.
      restart(8'hC0);
      runQuiet(321, 8'hC0);
      checkOutput("slowPos", 32'(pos), 32'd5);
      checkOutput("slowLed", 32'(led), 32'h003C);

      // Reverse wrap from 0 to 15 then 14.
      restart(8'h1F);
      runQuiet(5, 8'h1F);
      checkOutput("revPos", 32'(pos), 32'd15);
      checkOutput("revLed", 32'(led), 32'h8000);
      runQuiet(4, 8'h1F);
      checkOutput("revPos2", 32'(pos), 32'd14);

      // Stop asserted exactly when a step is due, held for 10 cycles.
      restart(8'h0F);
      runQuiet(6, 8'h0F);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (stepDue()) found = 1'b1;
         else applyStimulus(1'b0, 1'b0, 8'h0F);
      end
      checkOutput("stopWindowFound", 32'(found), 32'd1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h0F);
      applyStimulus(1'b0, 1'b0, 8'h0F);
      checkOutput("pausedHeld", 32'(paused), 32'd1);
      checkOutput("pausedNoPulse", 32'(step_pulse), 32'd0);
      runQuiet(2, 8'h0F);
      checkOutput("resumePulse", 32'(step_pulse), 32'd1);
      checkOutput("resumePaused", 32'(paused), 32'd0);

      // Bounce at the top end (wraps instead when the feature is not built).
      restart(8'h2F);
      runQuiet(57, 8'h2F);
      checkOutput("bouncePos14", 32'(pos), 32'd14);
      runQuiet(4, 8'h2F);
      checkOutput("bouncePos15", 32'(pos), 32'd15);
      runQuiet(4, 8'h2F);
      checkOutput("bouncePosNext", 32'(pos), BOUNCE_BUILT ? 32'd14 : 32'd0);
      runQuiet(60, 8'h2F);

      // Reset in the middle of a period.
      restart(8'h0F);
      runQuiet(10, 8'h0F);
      applyStimulus(1'b1, 1'b0, 8'h0F);
      applyStimulus(1'b0, 1'b0, 8'h0F);
      checkOutput("midResetLed", 32'(led), 32'h0001);
      checkOutput("midResetPos", 32'(pos), 32'd0);
      checkOutput("midResetPulse", 32'(step_pulse), 32'd0);
      runQuiet(12, 8'h0F);

      // Randomized configurations with random stop bursts.
      for (int seg = 0; seg < 16; seg++) begin
         s = 8'($urandom);
         restart(s);
         runRandom($urandom_range(400, 60), s);
      end

      applyStimulus(1'b0, 1'b0, s);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
